// File: rtl/alu_mem_sequencer.sv
// rtl/alu_mem_sequencer.sv - batch sequencer feeding operand-memory pairs through an ALU
// Results are presented on a valid/ready port; every output is a flop.
module alu_mem_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W:0]   count,
  input  logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] addressA,
  output logic [ADDR_W-1:0] addressB,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  output logic [OP_W-1:0]   aluOp,
  input  logic [DATA_W-1:0] aluResult,
  output logic              resValid,
  input  logic              resReady,
  output logic [DATA_W-1:0] resData,
  output logic [ADDR_W-1:0] resIndex,
  output logic              resZero,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_index_q, res_index_d;
  logic              res_zero_q, res_zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_clamped;

  assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    res_zero_d  = res_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          alu_op_d    = opcode;
          remaining_d = count_clamped;
          index_d     = '0;
          if (count_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            addr_a_d = startAddr;
            addr_b_d = startAddr + ADDR_W'(1);
            state_d  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        alu_a_d = dataA;
        alu_b_d = dataB;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_data_d  = aluResult;
        res_zero_d  = (aluResult == '0);
        res_index_d = index_q;
        res_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (resReady) begin
          res_valid_d = 1'b0;
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d = S_DONE;
          end else begin
            addr_a_d = addr_a_q + ADDR_W'(2);
            addr_b_d = addr_b_q + ADDR_W'(2);
            index_d  = index_q + ADDR_W'(1);
            state_d  = S_FETCH;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over the result handshake and suppresses the done pulse.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      index_q     <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
      res_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
      res_zero_q  <= res_zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign addressA = addr_a_q;
  assign addressB = addr_b_q;
  assign aluA     = alu_a_q;
  assign aluB     = alu_b_q;
  assign aluOp    = alu_op_q;
  assign resValid = res_valid_q;
  assign resData  = res_data_q;
  assign resIndex = res_index_q;
  assign resZero  = res_zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
